// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the hazard scoreboard.
// Optional build macro: HAZ_PERF_CNT_EN adds saturating stall counters.
package hazard_pkg;

   // Operand select encoding shared by the D and E forwarding muxes
   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_t;

   // Multiply/divide sequencer states
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } mdu_state_t;

   // Increment that sticks at all-ones instead of wrapping
   function automatic logic [31:0] satInc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/hazard_scoreboard_mdu_seq.sv
// Multiply/divide sequencer: holds E while a multi-cycle op runs,
// then pulses done for one cycle with E released.
module mdu_seq
   import hazard_pkg::*;
#(
   parameter int DIV_LAT = 32,
   parameter int MUL_LAT = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic is_div,
   input  logic flush,
   output logic stall,
   output logic busy,
   output logic done
);

   localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
   localparam int CW      = $clog2(MAX_LAT + 1);

   mdu_state_t    state_q;
   logic [CW-1:0] count_q;

   // State and down-counter; a flush abandons the op and clears the count
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         count_q <= '0;
      end else if (flush) begin
         state_q <= IDLE;
         count_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= BUSY;
                  count_q <= is_div ? CW'(DIV_LAT - 1) : CW'(MUL_LAT - 1);
               end
            end
            BUSY: begin
               if (count_q == '0) begin
                  state_q <= DONE;
               end else begin
                  count_q <= count_q - 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
               count_q <= '0;
            end
         endcase
      end
   end

   // E holds on the start cycle and through BUSY; the DONE cycle releases it
   always_comb begin
      stall = !flush && (((state_q == IDLE) && start) || (state_q == BUSY));
      busy  = (state_q != IDLE);
      done  = (state_q == DONE) && !flush;
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for the 5-stage pipeline: forwarding selects, load/branch
// stalls, multi-cycle mult/div hold and exception flush.
// Optional build macro: HAZ_PERF_CNT_EN adds perf_* stall counters.
module hazard_scoreboard
   import hazard_pkg::*;
#(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int DIV_LAT  = 32,
   parameter int MUL_LAT  = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rsD,
   input  logic [REG_AW-1:0] rtD,
   input  logic              branchD,
   input  logic              jrD,
   input  logic [REG_AW-1:0] rsE,
   input  logic [REG_AW-1:0] rtE,
   input  logic [REG_AW-1:0] writeregE,
   input  logic              regwriteE,
   input  logic              memtoregE,
   input  logic              mdu_startE,
   input  logic              mdu_is_divE,
   input  logic [REG_AW-1:0] writeregM,
   input  logic              regwriteM,
   input  logic              memtoregM,
   input  logic [REG_AW-1:0] writeregW,
   input  logic              regwriteW,
   input  logic              flush_exc,
   output logic [1:0]        forwardaD,
   output logic [1:0]        forwardbD,
   output logic [1:0]        forwardaE,
   output logic [1:0]        forwardbE,
   output logic              stallF,
   output logic              stallD,
   output logic              stallE,
   output logic              flushD,
   output logic              flushE,
   output logic              flushM,
   output logic              mdu_busy,
   output logic              mdu_done
`ifdef HAZ_PERF_CNT_EN
   ,
   output logic [31:0]       perf_ld_stall,
   output logic [31:0]       perf_br_stall,
   output logic [31:0]       perf_mdu_stall
`endif
);

   logic lwStall;
   logic brStall;
   logic jrStall;
   logic hazStall;
   logic mduStall;

   // Register 0 is hardwired, so it never creates a dependency
   function automatic logic regHit(input logic [REG_AW-1:0] a, input logic [REG_AW-1:0] b);
      return (a != '0) && (a == b);
   endfunction

   function automatic fwd_sel_t fwdSel(input logic [REG_AW-1:0] src,
                                       input logic              mEn,
                                       input logic [REG_AW-1:0] mReg,
                                       input logic              wEn,
                                       input logic [REG_AW-1:0] wReg);
      if (mEn && regHit(src, mReg)) return FWD_M;
      if (wEn && regHit(src, wReg)) return FWD_W;
      return FWD_RF;
   endfunction

   mdu_seq #(
      .DIV_LAT(DIV_LAT),
      .MUL_LAT(MUL_LAT)
   ) u_mdu_seq (
      .clk   (clk),
      .rst   (rst),
      .start (mdu_startE),
      .is_div(mdu_is_divE),
      .flush (flush_exc),
      .stall (mduStall),
      .busy  (mdu_busy),
      .done  (mdu_done)
   );

   // Forward selects; a load in M has no data yet so D cannot take it
   always_comb begin
      forwardaE = fwdSel(rsE, regwriteM, writeregM, regwriteW, writeregW);
      forwardbE = fwdSel(rtE, regwriteM, writeregM, regwriteW, writeregW);
      forwardaD = fwdSel(rsD, regwriteM && !memtoregM, writeregM, regwriteW, writeregW);
      forwardbD = fwdSel(rtD, regwriteM && !memtoregM, writeregM, regwriteW, writeregW);
   end

   // Data hazards that require D to wait
   always_comb begin
      lwStall = memtoregE && (regHit(rtE, rsD) || regHit(rtE, rtD));
      if (LOAD_LAT == 2) begin
         lwStall = lwStall || (memtoregM && (regHit(writeregM, rsD) || regHit(writeregM, rtD)));
      end
      brStall = branchD &&
                ((regwriteE && (regHit(writeregE, rsD) || regHit(writeregE, rtD))) ||
                 (memtoregM && (regHit(writeregM, rsD) || regHit(writeregM, rtD))));
      jrStall = jrD &&
                ((regwriteE && regHit(writeregE, rsD)) ||
                 (memtoregM && regHit(writeregM, rsD)));
      hazStall = lwStall || brStall || jrStall;
   end

   // Stall and flush outputs; an exception flush overrides every stall
   always_comb begin
      stallE = mduStall;
      stallD = !flush_exc && (hazStall || mduStall);
      stallF = stallD;
      flushD = flush_exc;
      flushE = flush_exc || (hazStall && !mduStall);
      flushM = flush_exc;
   end

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] perfLd_q, perfLd_d;
   logic [31:0] perfBr_q, perfBr_d;
   logic [31:0] perfMdu_q, perfMdu_d;

   // Next counter values; cycles under an exception flush are not counted
   always_comb begin
      perfLd_d  = perfLd_q;
      perfBr_d  = perfBr_q;
      perfMdu_d = perfMdu_q;
      if (!flush_exc) begin
         if (lwStall)             perfLd_d  = satInc(perfLd_q);
         if (brStall || jrStall)  perfBr_d  = satInc(perfBr_q);
         if (mduStall)            perfMdu_d = satInc(perfMdu_q);
      end
   end

   // Counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perfLd_q  <= '0;
         perfBr_q  <= '0;
         perfMdu_q <= '0;
      end else begin
         perfLd_q  <= perfLd_d;
         perfBr_q  <= perfBr_d;
         perfMdu_q <= perfMdu_d;
      end
   end

   assign perf_ld_stall  = perfLd_q;
   assign perf_br_stall  = perfBr_q;
   assign perf_mdu_stall = perfMdu_q;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: two instances with different
// latency parameters, directed scenarios plus randomized traffic, all
// compared against a behavioural model kept here.
module tb_hazard_scoreboard;

   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;

   logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
   logic branchD, jrD, regwriteE, memtoregE, mdu_startE, mdu_is_divE;
   logic regwriteM, memtoregM, regwriteW, flush_exc;

   logic [1:0] fwdAD [2];
   logic [1:0] fwdBD [2];
   logic [1:0] fwdAE [2];
   logic [1:0] fwdBE [2];
   logic stF [2];
   logic stD [2];
   logic stE [2];
   logic flD [2];
   logic flE [2];
   logic flM [2];
   logic busy [2];
   logic done [2];
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] pLd [2];
   logic [31:0] pBr [2];
   logic [31:0] pMdu [2];
`endif

   int checkCount = 0;
   int errorCount = 0;

   // Model: instance 0 = LOAD_LAT 1, DIV 32, MUL 1; instance 1 = LOAD_LAT 2, DIV 4, MUL 3
   int          loadLat [2] = '{1, 2};
   int          divLat  [2] = '{32, 4};
   int          mulLat  [2] = '{1, 3};
   int          mLeft   [2];
   bit          mDone   [2];
   logic [31:0] perfM   [2][3];

   always #5 clk = ~clk;

   hazard_scoreboard #(.REG_AW(AW), .LOAD_LAT(1), .DIV_LAT(32), .MUL_LAT(1)) u0 (
      .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
      .memtoregE(memtoregE), .mdu_startE(mdu_startE), .mdu_is_divE(mdu_is_divE),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .writeregW(writeregW), .regwriteW(regwriteW), .flush_exc(flush_exc),
      .forwardaD(fwdAD[0]), .forwardbD(fwdBD[0]), .forwardaE(fwdAE[0]), .forwardbE(fwdBE[0]),
      .stallF(stF[0]), .stallD(stD[0]), .stallE(stE[0]),
      .flushD(flD[0]), .flushE(flE[0]), .flushM(flM[0]),
      .mdu_busy(busy[0]), .mdu_done(done[0])
`ifdef HAZ_PERF_CNT_EN
      , .perf_ld_stall(pLd[0]), .perf_br_stall(pBr[0]), .perf_mdu_stall(pMdu[0])
`endif
   );

   hazard_scoreboard #(.REG_AW(AW), .LOAD_LAT(2), .DIV_LAT(4), .MUL_LAT(3)) u1 (
      .clk(clk), .rst(rst), .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
      .rsE(rsE), .rtE(rtE), .writeregE(writeregE), .regwriteE(regwriteE),
      .memtoregE(memtoregE), .mdu_startE(mdu_startE), .mdu_is_divE(mdu_is_divE),
      .writeregM(writeregM), .regwriteM(regwriteM), .memtoregM(memtoregM),
      .writeregW(writeregW), .regwriteW(regwriteW), .flush_exc(flush_exc),
      .forwardaD(fwdAD[1]), .forwardbD(fwdBD[1]), .forwardaE(fwdAE[1]), .forwardbE(fwdBE[1]),
      .stallF(stF[1]), .stallD(stD[1]), .stallE(stE[1]),
      .flushD(flD[1]), .flushE(flE[1]), .flushM(flM[1]),
      .mdu_busy(busy[1]), .mdu_done(done[1])
`ifdef HAZ_PERF_CNT_EN
      , .perf_ld_stall(pLd[1]), .perf_br_stall(pBr[1]), .perf_mdu_stall(pMdu[1])
`endif
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   function automatic string tagOf(input int i, input string n);
      return $sformatf("u%0d.%s", i, n);
   endfunction

   // Does register r feed either D-stage source operand?
   function automatic bit readByD(input logic [AW-1:0] r);
      return (r != 0) && ((r == rsD) || (r == rtD));
   endfunction

   function automatic bit lwHaz(input int i);
      bit loadInE = memtoregE && readByD(rtE);
      bit loadInM = (loadLat[i] == 2) && memtoregM && readByD(writeregM);
      return loadInE || loadInM;
   endfunction

   function automatic bit brHaz();
      return branchD && ((regwriteE && readByD(writeregE)) || (memtoregM && readByD(writeregM)));
   endfunction

   function automatic bit jrHaz();
      bit eDep = regwriteE && (writeregE != 0) && (writeregE == rsD);
      bit mDep = memtoregM && (writeregM != 0) && (writeregM == rsD);
      return jrD && (eDep || mDep);
   endfunction

   function automatic logic [1:0] fwdE(input logic [AW-1:0] src);
      if (src == 0) return 2'b00;
      if (regwriteM && (src == writeregM)) return 2'b10;
      if (regwriteW && (src == writeregW)) return 2'b01;
      return 2'b00;
   endfunction

   function automatic logic [1:0] fwdD(input logic [AW-1:0] src);
      if (src == 0) return 2'b00;
      if (regwriteM && !memtoregM && (src == writeregM)) return 2'b10;
      if (regwriteW && (src == writeregW)) return 2'b01;
      return 2'b00;
   endfunction

   // E is held while an op is about to start from idle or still has busy cycles left
   function automatic bit mduHold(input int i);
      bit idle = (mLeft[i] == 0) && !mDone[i];
      return !flush_exc && ((idle && mdu_startE) || (mLeft[i] > 0));
   endfunction

   task automatic modelReset();
      for (int i = 0; i < 2; i++) begin
         mLeft[i] = 0;
         mDone[i] = 1'b0;
         for (int k = 0; k < 3; k++) perfM[i][k] = 32'd0;
      end
   endtask

   // Advance the model by one clock edge using the inputs present at that edge
   task automatic modelAdvance();
      for (int i = 0; i < 2; i++) begin
         bit lw = lwHaz(i);
         bit bj = brHaz() || jrHaz();
         bit hold = mduHold(i);
         if (!flush_exc) begin
            if (lw   && perfM[i][0] != 32'hFFFF_FFFF) perfM[i][0] = perfM[i][0] + 1;
            if (bj   && perfM[i][1] != 32'hFFFF_FFFF) perfM[i][1] = perfM[i][1] + 1;
            if (hold && perfM[i][2] != 32'hFFFF_FFFF) perfM[i][2] = perfM[i][2] + 1;
         end
         if (flush_exc) begin
            mLeft[i] = 0;
            mDone[i] = 1'b0;
         end else if (mDone[i]) begin
            mDone[i] = 1'b0;
         end else if (mLeft[i] > 0) begin
            mLeft[i] = mLeft[i] - 1;
            if (mLeft[i] == 0) mDone[i] = 1'b1;
         end else if (mdu_startE) begin
            mLeft[i] = mdu_is_divE ? divLat[i] : mulLat[i];
         end
      end
   endtask

   // Compare every output of both instances against the model
   task automatic checkAll();
      for (int i = 0; i < 2; i++) begin
         bit hz = lwHaz(i) || brHaz() || jrHaz();
         bit sE = mduHold(i);
         bit sD = !flush_exc && (hz || sE);
         checkOutput(tagOf(i, "forwardaD"), 32'(fwdAD[i]), 32'(fwdD(rsD)));
         checkOutput(tagOf(i, "forwardbD"), 32'(fwdBD[i]), 32'(fwdD(rtD)));
         checkOutput(tagOf(i, "forwardaE"), 32'(fwdAE[i]), 32'(fwdE(rsE)));
         checkOutput(tagOf(i, "forwardbE"), 32'(fwdBE[i]), 32'(fwdE(rtE)));
         checkOutput(tagOf(i, "stallF"), 32'(stF[i]), 32'(sD));
         checkOutput(tagOf(i, "stallD"), 32'(stD[i]), 32'(sD));
         checkOutput(tagOf(i, "stallE"), 32'(stE[i]), 32'(sE));
         checkOutput(tagOf(i, "flushD"), 32'(flD[i]), 32'(flush_exc));
         checkOutput(tagOf(i, "flushE"), 32'(flE[i]), 32'(flush_exc || (hz && !sE)));
         checkOutput(tagOf(i, "flushM"), 32'(flM[i]), 32'(flush_exc));
         checkOutput(tagOf(i, "mdu_busy"), 32'(busy[i]), 32'((mLeft[i] > 0) || mDone[i]));
         checkOutput(tagOf(i, "mdu_done"), 32'(done[i]), 32'(mDone[i] && !flush_exc));
`ifdef HAZ_PERF_CNT_EN
         checkOutput(tagOf(i, "perf_ld"),  pLd[i],  perfM[i][0]);
         checkOutput(tagOf(i, "perf_br"),  pBr[i],  perfM[i][1]);
         checkOutput(tagOf(i, "perf_mdu"), pMdu[i], perfM[i][2]);
`endif
      end
   endtask

   task automatic clearInputs();
      rsD = '0; rtD = '0; rsE = '0; rtE = '0;
      writeregE = '0; writeregM = '0; writeregW = '0;
      branchD = 1'b0; jrD = 1'b0; regwriteE = 1'b0; memtoregE = 1'b0;
      mdu_startE = 1'b0; mdu_is_divE = 1'b0;
      regwriteM = 1'b0; memtoregM = 1'b0; regwriteW = 1'b0; flush_exc = 1'b0;
   endtask

   task automatic checkEdge();
      @(negedge clk);
      checkAll();
   endtask

   task automatic advance();
      @(posedge clk);
      modelAdvance();
      #1;
   endtask

   task automatic tick();
      checkEdge();
      advance();
   endtask

   task automatic drain(input int n);
      clearInputs();
      for (int c = 0; c < n; c++) tick();
   endtask

   task automatic doReset();
      clearInputs();
      rst = 1'b1;
      modelReset();
      @(negedge clk);
      checkAll();
      rst = 1'b0;
      advance();
   endtask

   // Random pipeline traffic over a small register set so dependencies are common
   task automatic applyStimulus();
      rsD = AW'($urandom_range(0, 3));
      rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3));
      rtE = AW'($urandom_range(0, 3));
      writeregE = AW'($urandom_range(0, 3));
      writeregM = AW'($urandom_range(0, 3));
      writeregW = AW'($urandom_range(0, 3));
      branchD   = ($urandom_range(0, 3) == 0);
      jrD       = ($urandom_range(0, 5) == 0);
      regwriteE = 1'($urandom_range(0, 1));
      memtoregE = ($urandom_range(0, 2) == 0);
      regwriteM = 1'($urandom_range(0, 1));
      memtoregM = ($urandom_range(0, 2) == 0);
      regwriteW = 1'($urandom_range(0, 1));
      mdu_startE  = ($urandom_range(0, 5) == 0);
      mdu_is_divE = ($urandom_range(0, 3) == 0);
      flush_exc   = ($urandom_range(0, 29) == 0);
   endtask

   initial begin
      int stallCnt;
      bit seenDone;

      doReset();

      // Forwarding priority and the register-0 exclusion
      rsE = 5'd3; regwriteM = 1'b1; writeregM = 5'd3; regwriteW = 1'b1; writeregW = 5'd3;
      checkEdge();
      checkOutput("fwdE_prefers_M", 32'(fwdAE[0]), 32'h2);
      advance();
      regwriteM = 1'b0;
      checkEdge();
      checkOutput("fwdE_from_W", 32'(fwdAE[0]), 32'h1);
      advance();
      regwriteM = 1'b1; rsE = 5'd0;
      checkEdge();
      checkOutput("fwdE_reg0", 32'(fwdAE[0]), 32'h0);
      advance();

      // Load-use: one stall cycle, a second only with LOAD_LAT=2
      clearInputs();
      memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
      checkEdge();
      checkOutput("lw_stallF", 32'(stF[0]), 32'h1);
      checkOutput("lw_stallD", 32'(stD[0]), 32'h1);
      checkOutput("lw_flushE", 32'(flE[0]), 32'h1);
      advance();
      clearInputs();
      memtoregM = 1'b1; writeregM = 5'd8; rsD = 5'd8;
      checkEdge();
      checkOutput("lw_lat1_released", 32'(stD[0]), 32'h0);
      checkOutput("lw_lat2_second", 32'(stD[1]), 32'h1);
      advance();

      // Divide on the 32-cycle instance: 33 held cycles then a done pulse
      drain(2);
      mdu_startE = 1'b1; mdu_is_divE = 1'b1;
      stallCnt = 0; seenDone = 1'b0;
      for (int c = 0; c < 80 && !seenDone; c++) begin
         checkEdge();
         if (stE[0]) stallCnt++;
         if (done[0]) begin
            seenDone = 1'b1;
            checkOutput("div_done_releases_E", 32'(stE[0]), 32'h0);
         end
         advance();
         if (seenDone) mdu_startE = 1'b0;
      end
      checkOutput("div_done_seen", 32'(seenDone), 32'h1);
      checkOutput("div_stall_cycles", 32'(stallCnt), 32'd33);

      // Multiply, then a second op entering straight after DONE
      drain(8);
      mdu_startE = 1'b1; mdu_is_divE = 1'b0;
      stallCnt = 0; seenDone = 1'b0;
      for (int c = 0; c < 20 && !seenDone; c++) begin
         checkEdge();
         if (stE[0]) stallCnt++;
         if (done[0]) seenDone = 1'b1;
         advance();
      end
      checkOutput("mul_done_seen", 32'(seenDone), 32'h1);
      checkOutput("mul_stall_cycles", 32'(stallCnt), 32'd2);
      checkEdge();
      checkOutput("b2b_restart_stall", 32'(stE[0]), 32'h1);
      checkOutput("b2b_from_idle", 32'(busy[0]), 32'h0);
      advance();

      // Exception flush on the 10th divide cycle
      drain(40);
      mdu_startE = 1'b1; mdu_is_divE = 1'b1;
      for (int c = 0; c < 9; c++) tick();
      flush_exc = 1'b1;
      checkEdge();
      checkOutput("abort_flushD", 32'(flD[0]), 32'h1);
      checkOutput("abort_flushE", 32'(flE[0]), 32'h1);
      checkOutput("abort_flushM", 32'(flM[0]), 32'h1);
      checkOutput("abort_stallE", 32'(stE[0]), 32'h0);
      advance();
      flush_exc = 1'b0; mdu_startE = 1'b0;
      checkEdge();
      checkOutput("abort_idle", 32'(busy[0]), 32'h0);
      checkOutput("abort_no_done", 32'(done[0]), 32'h0);
      advance();

      // Branch dependency, alone and alongside a busy divide
      drain(6);
      branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
      checkEdge();
      checkOutput("br_stallD", 32'(stD[0]), 32'h1);
      checkOutput("br_flushE", 32'(flE[0]), 32'h1);
      advance();
      clearInputs();
      mdu_startE = 1'b1; mdu_is_divE = 1'b1;
      tick();
      branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd5; rtD = 5'd5;
      checkEdge();
      checkOutput("br_busy_stallD", 32'(stD[0]), 32'h1);
      checkOutput("br_busy_noFlushE", 32'(flE[0]), 32'h0);
      advance();

      // Reset in the middle of a divide aborts at once
      drain(40);
      mdu_startE = 1'b1; mdu_is_divE = 1'b1;
      for (int c = 0; c < 5; c++) tick();
      rst = 1'b1;
      mdu_startE = 1'b0;
      #1;
      checkOutput("rst_mid_busy", 32'(busy[0]), 32'h0);
      checkOutput("rst_mid_stallE", 32'(stE[0]), 32'h0);
      doReset();

`ifdef HAZ_PERF_CNT_EN
      // One load-use stall and a 4-cycle divide on the second instance
      memtoregE = 1'b1; rtE = 5'd8; rsD = 5'd8;
      tick();
      clearInputs();
      mdu_startE = 1'b1; mdu_is_divE = 1'b1;
      seenDone = 1'b0;
      for (int c = 0; c < 20 && !seenDone; c++) begin
         checkEdge();
         if (done[1]) begin
            seenDone = 1'b1;
            checkOutput("perf_ld_count", pLd[1], 32'd1);
            checkOutput("perf_mdu_count", pMdu[1], 32'd5);
         end
         advance();
      end
      checkOutput("perf_div_done_seen", 32'(seenDone), 32'h1);
      doReset();
`endif

      // Randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         applyStimulus();
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised next-generation hazard unit for the 5-stage MIPS pipeline (F/D/E/M/W).
- Adds a multi-cycle multiply/divide sequencer (FSM + down-counter) that holds E for a configurable latency.
- Adds configurable load latency, 2-bit forwarding into D, and an exception flush.
- Sits beside the datapath; drives all stall, flush and forward selects.

Parameters:
- REG_AW, 5, register-index width.
- LOAD_LAT, 1, cycles the load result trails E; legal values 1 or 2.
- DIV_LAT, 32, divide busy cycles; minimum 1.
- MUL_LAT, 1, multiply busy cycles; minimum 1.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous active-high reset
- rsD, rtD  in  REG_AW  D-stage source registers
- branchD, jrD  in  1  D-stage branch compare / jr needs operands in D
- rsE, rtE, writeregE  in  REG_AW  E-stage registers
- regwriteE, memtoregE  in  1  E-stage controls
- mdu_startE  in  1  mult/div instruction in E
- mdu_is_divE  in  1  1 = divide, 0 = multiply
- writeregM  in  REG_AW; regwriteM, memtoregM  in  1  M-stage controls
- writeregW  in  REG_AW; regwriteW  in  1  W-stage controls
- flush_exc  in  1  exception/redirect flush
- forwardaD, forwardbD  out  2  D operand select: 00 regfile, 01 W, 10 M
- forwardaE, forwardbE  out  2  E operand select, same encoding
- stallF, stallD, stallE  out  1  stage holds
- flushD, flushE, flushM  out  1  stage bubbles
- mdu_busy  out  1  sequencer not IDLE
- mdu_done  out  1  one-cycle result-valid pulse

Behaviour:
- Register index 0 never matches any hazard or forward term.
- Forward E: M match with regwriteM gives 10; else W match with regwriteW gives 01; else 00. M has priority.
- Forward D: M match with regwriteM and !memtoregM gives 10; else W match gives 01; else 00.
- lwstall: memtoregE and rtE nonzero and rtE equals rsD or rtD.
- When LOAD_LAT=2, lwstall also fires for memtoregM and writeregM matching rsD or rtD.
- brstall: branchD and one of:
  - regwriteE and writeregE matches rsD or rtD;
  - memtoregM and writeregM matches rsD or rtD.
- jrstall: same as brstall but rsD only; gated by jrD.
- Sequencer states: IDLE, BUSY, DONE; counter width is $clog2(max(DIV_LAT,MUL_LAT)+1).
  - IDLE: when mdu_startE and !flush_exc, go to BUSY; counter loads DIV_LAT-1 or MUL_LAT-1.
  - BUSY: decrement each cycle; at 0 go to DONE.
  - DONE: mdu_done=1, then IDLE unconditionally. mdu_startE is ignored in DONE (same instruction still in E).
- stallE = (IDLE and mdu_startE) or BUSY. E is held for exactly LAT+1 cycles and released in DONE.
- stallD = lwstall | brstall | jrstall | stallE; stallF = stallD.
- flushE = (lwstall | brstall | jrstall) and !stallE. Never bubble an E stage that is holding.
- flush_exc has priority:
  - flushD, flushE and flushM are driven to 1.
  - All stalls are forced to 0.
  - The sequencer returns to IDLE with the counter cleared; mdu_done is not pulsed.
- Reset: sequencer IDLE, counter 0, mdu_busy=0, mdu_done=0. With inputs at 0, all outputs are 0.
- Reset asserted mid-divide aborts immediately.
- Back-to-back mult/div: a second op entering E the cycle after DONE starts from IDLE with no gap.

Optional Feature:
- Macro HAZ_PERF_CNT_EN.
- When defined, three 32-bit output ports are added:
  - perf_ld_stall counts cycles of lwstall;
  - perf_br_stall counts cycles of brstall or jrstall;
  - perf_mdu_stall counts cycles of stallE.
- Each counts only while flush_exc=0, saturates at all-ones, and is cleared by rst.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - fwd_sel_t with values FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10;
  - mdu_state_t with values IDLE, BUSY, DONE.
- One sub-module, mdu_seq, owns the FSM and counter. Outputs: stall, busy, done. Inputs: start, is_div, flush.
- All compare and forward logic stays combinational in the top module.

Test Plan:
- Forwarding:
  - rsE=3; regwriteM with writeregM=3; regwriteW with writeregW=3 -> forwardaE=10.
  - Drop regwriteM -> forwardaE=01.
  - rsE=0 with the same M/W writes -> 00.
- Load-use:
  - memtoregE, rtE=8, rsD=8 -> stallF=stallD=flushE=1 for 1 cycle.
  - With LOAD_LAT=2 -> stall for 2 cycles.
- Divide:
  - mdu_startE, mdu_is_divE, DIV_LAT=32 -> stallE=1 for 33 cycles.
  - mdu_done pulses in the 34th cycle with stallE=0.
  - Multiply with MUL_LAT=1 -> stallE=1 for 2 cycles.
- Abort: flush_exc at divide cycle 10 -> same cycle flushD/E/M=1 and stallE=0; next cycle mdu_busy=0; no mdu_done.
- Branch: branchD, regwriteE with writeregE=rtD=5 -> stallD=1 and flushE=1. Concurrent divide BUSY -> flushE=0 and stallD=1.
- Perf (HAZ_PERF_CNT_EN): one load-use stall plus one divide with DIV_LAT=4 -> perf_ld_stall=1, perf_mdu_stall=5.
